// File: rtl/dpram_pkg.sv
// dpram_pkg: shared definitions for the dpram_io_bridge register window.
//   - register offsets decoded from the 4-bit J1 I/O offset
//   - FSM state type for the clear sweep
//   - STATUS bit positions and a helper that packs the STATUS word
// Optional feature macro used by the bridge: DPRAM_AUTOINC_EN.
package dpram_pkg;

  localparam logic [3:0] REG_DATA_WR = 4'h0;
  localparam logic [3:0] REG_DATA_RD = 4'h2;
  localparam logic [3:0] REG_ADDR    = 4'h4;
  localparam logic [3:0] REG_STATUS  = 4'h6;
  localparam logic [3:0] REG_INIT    = 4'h8;
  localparam logic [3:0] REG_CTRL    = 4'hA;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_ERR     = 1;
  localparam int STAT_RD_PEND = 2;

  // Pack the STATUS register; all unused upper bits read as zero.
  function automatic logic [15:0] status_word(input logic rd_pend,
                                              input logic err,
                                              input logic busy);
    logic [15:0] w;
    w               = 16'h0000;
    w[STAT_BUSY]    = busy;
    w[STAT_ERR]     = err;
    w[STAT_RD_PEND] = rd_pend;
    return w;
  endfunction

endpackage

// File: rtl/dpram_core.sv
// dpram_core: true dual-port synchronous RAM, DEPTH = 2**AW words of DW bits.
// Ports:
//   clk, rst_n          clock, async active-low reset (output registers only)
//   a_we/a_addr/a_din   port A write; a_dout = mem[a_addr] one edge later
//   b_we/b_addr/b_din   port B write; b_dout = mem[b_addr] one edge later
// Same-address writes on both ports store the port A value. A read that
// collides with a write returns the word as it was before the write.
// The storage array itself is not reset.
module dpram_core #(
  parameter int DW = 16,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_din,
  output logic [DW-1:0] a_dout,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_din,
  output logic [DW-1:0] b_dout
);

  localparam int DEPTH = 32'd1 << AW;

  logic [DW-1:0] mem_r [0:DEPTH-1];

  // Storage writes: port A is written last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (b_we) mem_r[b_addr] <= b_din;
    if (a_we) mem_r[a_addr] <= a_din;
  end

  // Port A registered read (old data on read-during-write).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) a_dout <= {DW{1'b0}};
    else        a_dout <= mem_r[a_addr];
  end

  // Port B registered read (old data on read-during-write).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) b_dout <= {DW{1'b0}};
    else        b_dout <= mem_r[b_addr];
  end

endmodule

// File: rtl/dpram_io_bridge.sv
// dpram_io_bridge: J1 I/O register window onto port A of a dual-port RAM.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   cs, addr, wr, rd      J1 I/O strobe; write = cs&&wr, read = cs&&rd&&!wr
//   dat_in / dat_out      CPU write data / registered CPU read data
//   b_addr/b_din/b_we     port B of the RAM, passed straight through
//   b_dout                port B read data, 1-cycle latency
//   busy                  clear sweep in progress
// Registers: DATA_WR 0x0, DATA_RD 0x2, ADDR 0x4, STATUS 0x6, INIT 0x8, CTRL 0xA.
// Build option: define DPRAM_AUTOINC_EN to get the autoinc bit / CTRL
// register; without it the pointer never advances on data accesses.
module dpram_io_bridge
  import dpram_pkg::*;
#(
  parameter int DW = 16,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cs,
  input  logic [3:0]    addr,
  input  logic          wr,
  input  logic          rd,
  input  logic [15:0]   dat_in,
  output logic [15:0]   dat_out,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_din,
  input  logic          b_we,
  output logic [DW-1:0] b_dout,
  output logic          busy
);

  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

  state_t        state_r;
  logic [AW-1:0] ptr_r;
  logic [AW-1:0] clr_cnt_r;
  logic          busy_r;
  logic          err_r;
  logic          rd_pend_r;
  logic          autoinc_s;
  logic          ctrl_err_s;

  logic          do_wr_s;
  logic          do_rd_s;
  logic          clearing_s;
  logic          data_wr_s;
  logic          data_rd_s;
  logic          addr_wr_s;
  logic          addr_rd_s;
  logic          stat_wr_s;
  logic          stat_rd_s;
  logic          init_wr_s;

  logic          port_a_we_s;
  logic [AW-1:0] port_a_addr_s;
  logic [DW-1:0] port_a_din_s;
  logic [DW-1:0] port_a_dout_s;
  logic [15:0]   rd_word_s;
  logic [15:0]   ptr_word_s;

  // Strobe decode; a simultaneous write wins over a read.
  always_comb begin
    do_wr_s    = cs && wr;
    do_rd_s    = cs && rd && !wr;
    clearing_s = (state_r == ST_CLEAR);
    data_wr_s  = do_wr_s && (addr == REG_DATA_WR);
    data_rd_s  = do_rd_s && (addr == REG_DATA_RD);
    addr_wr_s  = do_wr_s && (addr == REG_ADDR);
    addr_rd_s  = do_rd_s && (addr == REG_ADDR);
    stat_wr_s  = do_wr_s && (addr == REG_STATUS);
    stat_rd_s  = do_rd_s && (addr == REG_STATUS);
    init_wr_s  = do_wr_s && (addr == REG_INIT);
  end

`ifdef DPRAM_AUTOINC_EN
  logic ctrl_wr_s;
  logic autoinc_r;

  assign ctrl_wr_s  = do_wr_s && (addr == REG_CTRL);
  assign ctrl_err_s = ctrl_wr_s;
  assign autoinc_s  = autoinc_r;

  // Auto-increment enable, writable through CTRL outside the sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         autoinc_r <= 1'b1;
    else if (ctrl_wr_s && !clearing_s)  autoinc_r <= dat_in[0];
  end
`else
  assign ctrl_err_s = 1'b0;
  assign autoinc_s  = 1'b0;
`endif

  // Port A belongs to the sweep while clearing, otherwise to the CPU pointer.
  always_comb begin
    if (clearing_s) begin
      port_a_we_s   = 1'b1;
      port_a_addr_s = clr_cnt_r;
      port_a_din_s  = {DW{1'b0}};
    end else begin
      port_a_we_s   = data_wr_s;
      port_a_addr_s = ptr_r;
      port_a_din_s  = dat_in[DW-1:0];
    end
  end

  // Zero-extend RAM word and pointer onto the 16-bit CPU bus.
  always_comb begin
    rd_word_s            = 16'h0000;
    rd_word_s[DW-1:0]    = port_a_dout_s;
    ptr_word_s           = 16'h0000;
    ptr_word_s[AW-1:0]   = ptr_r;
  end

  // Clear-sweep FSM; also owns the pointer since the sweep resets it on exit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      clr_cnt_r <= {AW{1'b0}};
      busy_r    <= 1'b0;
      ptr_r     <= {AW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (init_wr_s) begin
            state_r   <= ST_CLEAR;
            clr_cnt_r <= {AW{1'b0}};
            busy_r    <= 1'b1;
          end else if (addr_wr_s) begin
            ptr_r <= dat_in[AW-1:0];
          end else if ((data_wr_s || data_rd_s) && autoinc_s) begin
            ptr_r <= ptr_r + PTR_ONE;
          end
        end
        ST_CLEAR: begin
          // The last word is written on the same edge that leaves CLEAR.
          if (&clr_cnt_r) begin
            state_r   <= ST_IDLE;
            clr_cnt_r <= {AW{1'b0}};
            busy_r    <= 1'b0;
            ptr_r     <= {AW{1'b0}};
          end else begin
            clr_cnt_r <= clr_cnt_r + PTR_ONE;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          clr_cnt_r <= {AW{1'b0}};
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

  // Sticky error: CPU data/pointer/control access attempted during the sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_r <= 1'b0;
    else if (clearing_s && (data_wr_s || data_rd_s || addr_wr_s || ctrl_err_s))
      err_r <= 1'b1;
    else if (stat_wr_s && dat_in[STAT_ERR])
      err_r <= 1'b0;
  end

  // Read pipeline tag: RAM output is valid for dat_out one cycle after DATA_RD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_pend_r <= 1'b0;
    else        rd_pend_r <= data_rd_s && !clearing_s;
  end

  // CPU read data register; holds unless a read source is selected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          dat_out <= 16'h0000;
    else if (rd_pend_r)  dat_out <= rd_word_s;
    else if (addr_rd_s)  dat_out <= ptr_word_s;
    else if (stat_rd_s)  dat_out <= status_word(rd_pend_r, err_r, busy_r);
  end

  assign busy = busy_r;

  dpram_core #(
    .DW(DW),
    .AW(AW)
  ) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .a_we  (port_a_we_s),
    .a_addr(port_a_addr_s),
    .a_din (port_a_din_s),
    .a_dout(port_a_dout_s),
    .b_we  (b_we),
    .b_addr(b_addr),
    .b_din (b_din),
    .b_dout(b_dout)
  );

endmodule

// File: tb/tb_dpram_io_bridge.sv
// Directed self-checking bench for dpram_io_bridge (DW=16, AW=8).
module tb_dpram_io_bridge;

  logic        clk;
  logic        rst_n;
  logic        cs;
  logic [3:0]  addr;
  logic        wr;
  logic        rd;
  logic [15:0] dat_in;
  logic [15:0] dat_out;
  logic [7:0]  b_addr;
  logic [15:0] b_din;
  logic        b_we;
  logic [15:0] b_dout;
  logic        busy;

  int n_cmp = 0;
  int n_mis = 0;

  localparam logic [3:0] A_DWR  = 4'h0;
  localparam logic [3:0] A_DRD  = 4'h2;
  localparam logic [3:0] A_ADDR = 4'h4;
  localparam logic [3:0] A_STAT = 4'h6;
  localparam logic [3:0] A_INIT = 4'h8;
  localparam logic [3:0] A_CTRL = 4'hA;

  dpram_io_bridge #(.DW(16), .AW(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .cs     (cs),
    .addr   (addr),
    .wr     (wr),
    .rd     (rd),
    .dat_in (dat_in),
    .dat_out(dat_out),
    .b_addr (b_addr),
    .b_din  (b_din),
    .b_we   (b_we),
    .b_dout (b_dout),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic cpu_write(input logic [3:0] a, input logic [15:0] d);
    cs = 1'b1; wr = 1'b1; rd = 1'b0; addr = a; dat_in = d;
    @(posedge clk); #1;
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic cpu_read(input logic [3:0] a);
    cs = 1'b1; wr = 1'b0; rd = 1'b1; addr = a;
    @(posedge clk); #1;
    cs = 1'b0; rd = 1'b0;
  endtask

  task automatic b_write(input logic [7:0] a, input logic [15:0] d);
    b_addr = a; b_din = d; b_we = 1'b1;
    @(posedge clk); #1;
    b_we = 1'b0;
  endtask

  task automatic b_read(input logic [7:0] a);
    b_addr = a; b_we = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    n_cmp++; if (dat_out !== 16'h0000) begin n_mis++; $display("FAIL reset_dat_out: got %h want 0000", dat_out); end
    n_cmp++; if (b_dout !== 16'h0000) begin n_mis++; $display("FAIL reset_b_dout: got %h want 0000", b_dout); end
    n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL reset_busy: got %b want 0", busy); end
    cpu_write(A_ADDR, 16'h0077);   // make dat_out nonzero before STATUS read
    cpu_read(A_ADDR);
    cpu_write(A_ADDR, 16'h0000);
    cpu_read(A_STAT);
    n_cmp++; if (dat_out !== 16'h0000) begin n_mis++; $display("FAIL reset_status: got %h want 0000", dat_out); end
  endtask

  task automatic test_addr_data();
    cpu_write(A_CTRL, 16'h0000);   // autoinc off where CTRL exists
    cpu_write(A_ADDR, 16'h1234);
    cpu_read(A_ADDR);
    n_cmp++; if (dat_out !== 16'h0034) begin n_mis++; $display("FAIL addr_readback: got %h want 0034", dat_out); end
    cpu_write(A_DWR, 16'hBEEF);
    cpu_write(A_ADDR, 16'h0035);
    cpu_write(A_DWR, 16'hCAFE);
    cpu_write(A_ADDR, 16'h0034);
    cpu_read(A_ADDR);
    cpu_read(A_DRD);
    n_cmp++; if (dat_out !== 16'h0034) begin n_mis++; $display("FAIL drd_latency: got %h want 0034", dat_out); end
    idle_cycle();
    n_cmp++; if (dat_out !== 16'hBEEF) begin n_mis++; $display("FAIL drd_data: got %h want beef", dat_out); end
    cpu_write(A_ADDR, 16'h0035);
    cpu_read(A_DRD);
    cpu_read(A_DRD);               // back-to-back
    n_cmp++; if (dat_out !== 16'hCAFE) begin n_mis++; $display("FAIL drd_b2b_first: got %h want cafe", dat_out); end
    idle_cycle();
    n_cmp++; if (dat_out !== 16'hCAFE) begin n_mis++; $display("FAIL drd_b2b_second: got %h want cafe", dat_out); end
    b_read(8'h34);
    n_cmp++; if (b_dout !== 16'hBEEF) begin n_mis++; $display("FAIL portb_sees_a: got %h want beef", b_dout); end
  endtask

  task automatic test_wr_rd_both();
    cs = 1'b1; wr = 1'b1; rd = 1'b1; addr = A_ADDR; dat_in = 16'h0041;
    @(posedge clk); #1; cs = 1'b0; wr = 1'b0; rd = 1'b0;
    n_cmp++; if (dat_out !== 16'hCAFE) begin n_mis++; $display("FAIL both_addr_no_read: got %h want cafe", dat_out); end
    cs = 1'b1; wr = 1'b1; rd = 1'b1; addr = A_DWR; dat_in = 16'h5A5A;
    @(posedge clk); #1; cs = 1'b0; wr = 1'b0; rd = 1'b0;
    idle_cycle();
    n_cmp++; if (dat_out !== 16'hCAFE) begin n_mis++; $display("FAIL both_data_no_read: got %h want cafe", dat_out); end
    b_read(8'h41);
    n_cmp++; if (b_dout !== 16'h5A5A) begin n_mis++; $display("FAIL both_write_done: got %h want 5a5a", b_dout); end
    cpu_read(A_ADDR);
    n_cmp++; if (dat_out !== 16'h0041) begin n_mis++; $display("FAIL both_ptr: got %h want 0041", dat_out); end
  endtask

  task automatic test_collision();
    cpu_write(A_ADDR, 16'h0010);
    cs = 1'b1; wr = 1'b1; addr = A_DWR; dat_in = 16'hAAAA;
    b_addr = 8'h10; b_din = 16'h5555; b_we = 1'b1;
    @(posedge clk); #1; cs = 1'b0; wr = 1'b0; b_we = 1'b0;
    b_read(8'h10);
    n_cmp++; if (b_dout !== 16'hAAAA) begin n_mis++; $display("FAIL ww_collision: got %h want aaaa", b_dout); end
    b_write(8'h20, 16'h1111);
    cpu_write(A_ADDR, 16'h0020);
    b_addr = 8'h20;
    cpu_write(A_DWR, 16'h2222);    // port B reads 0x20 on the same edge
    n_cmp++; if (b_dout !== 16'h1111) begin n_mis++; $display("FAIL b_read_old: got %h want 1111", b_dout); end
    b_read(8'h20);
    n_cmp++; if (b_dout !== 16'h2222) begin n_mis++; $display("FAIL b_read_new: got %h want 2222", b_dout); end
    cs = 1'b1; rd = 1'b1; addr = A_DRD;
    b_addr = 8'h20; b_din = 16'h3333; b_we = 1'b1;
    @(posedge clk); #1; cs = 1'b0; rd = 1'b0; b_we = 1'b0;
    idle_cycle();
    n_cmp++; if (dat_out !== 16'h2222) begin n_mis++; $display("FAIL a_read_old: got %h want 2222", dat_out); end
  endtask

  task automatic test_clear();
    int busy_cnt;
    int nz;
    for (int i = 0; i < 256; i++) b_write(i[7:0], {8'hC3, i[7:0]});
    cpu_write(A_ADDR, 16'h0001);
    cpu_write(A_INIT, 16'h0000);
    busy_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      if (busy === 1'b1) busy_cnt++;
      if (i == 2) begin cs = 1'b1; wr = 1'b1; addr = A_INIT; dat_in = 16'h0000; end
      if (i == 4 || i == 8) begin cs = 1'b1; rd = 1'b1; addr = A_STAT; end
      if (i == 6) begin cs = 1'b1; wr = 1'b1; addr = A_DWR; dat_in = 16'h9999; end
      @(posedge clk); #1;
      cs = 1'b0; wr = 1'b0; rd = 1'b0;
      if (i == 4) begin
        n_cmp++; if (dat_out !== 16'h0001) begin n_mis++; $display("FAIL clr_status_busy: got %h want 0001", dat_out); end
      end
      if (i == 8) begin
        n_cmp++; if (dat_out !== 16'h0003) begin n_mis++; $display("FAIL clr_status_err: got %h want 0003", dat_out); end
      end
    end
    n_cmp++; if (busy_cnt !== 256) begin n_mis++; $display("FAIL clr_busy_len: got %0d want 256", busy_cnt); end
    cpu_read(A_ADDR);
    n_cmp++; if (dat_out !== 16'h0000) begin n_mis++; $display("FAIL clr_ptr_zero: got %h want 0000", dat_out); end
    cpu_read(A_STAT);
    n_cmp++; if (dat_out !== 16'h0002) begin n_mis++; $display("FAIL clr_err_sticky: got %h want 0002", dat_out); end
    cpu_write(A_STAT, 16'h0002);
    cpu_read(A_STAT);
    n_cmp++; if (dat_out !== 16'h0000) begin n_mis++; $display("FAIL clr_err_cleared: got %h want 0000", dat_out); end
    nz = 0;
    for (int i = 0; i < 256; i++) begin
      b_read(i[7:0]);
      if (b_dout !== 16'h0000) nz++;
    end
    n_cmp++; if (nz !== 0) begin n_mis++; $display("FAIL clr_all_zero: got %0d nonzero words want 0", nz); end
  endtask

  task automatic test_reset_mid_sweep();
    for (int i = 0; i < 256; i++) b_write(i[7:0], {8'h5A, i[7:0]});
    cpu_write(A_ADDR, 16'h0022);
    cpu_read(A_ADDR);
    n_cmp++; if (dat_out !== 16'h0022) begin n_mis++; $display("FAIL rst_pre_ptr: got %h want 0022", dat_out); end
    cpu_write(A_INIT, 16'h0000);
    repeat (100) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (dat_out !== 16'h0000) begin n_mis++; $display("FAIL rst_dat_out: got %h want 0000", dat_out); end
    #1;
    rst_n = 1'b1;
    idle_cycle();
    cpu_read(A_ADDR);
    n_cmp++; if (dat_out !== 16'h0000) begin n_mis++; $display("FAIL rst_ptr: got %h want 0000", dat_out); end
    b_read(8'd99);
    n_cmp++; if (b_dout !== 16'h0000) begin n_mis++; $display("FAIL rst_w99: got %h want 0000", b_dout); end
    b_read(8'd100);
    n_cmp++; if (b_dout !== 16'h5A64) begin n_mis++; $display("FAIL rst_w100: got %h want 5a64", b_dout); end
    b_read(8'd255);
    n_cmp++; if (b_dout !== 16'h5AFF) begin n_mis++; $display("FAIL rst_w255: got %h want 5aff", b_dout); end
  endtask

`ifdef DPRAM_AUTOINC_EN
  task automatic test_autoinc();
    cpu_write(A_CTRL, 16'h0001);
    cpu_write(A_ADDR, 16'h1234);
    cpu_write(A_DWR, 16'hBEEF);
    cpu_write(A_DWR, 16'hCAFE);
    cpu_write(A_ADDR, 16'h0034);
    cpu_read(A_DRD);
    cpu_read(A_DRD);
    n_cmp++; if (dat_out !== 16'hBEEF) begin n_mis++; $display("FAIL ai_first: got %h want beef", dat_out); end
    idle_cycle();
    n_cmp++; if (dat_out !== 16'hCAFE) begin n_mis++; $display("FAIL ai_second: got %h want cafe", dat_out); end
    cpu_read(A_ADDR);
    n_cmp++; if (dat_out !== 16'h0036) begin n_mis++; $display("FAIL ai_ptr: got %h want 0036", dat_out); end
    cpu_write(A_ADDR, 16'h00FF);
    cpu_write(A_DWR, 16'h0001);
    cpu_read(A_ADDR);
    n_cmp++; if (dat_out !== 16'h0000) begin n_mis++; $display("FAIL ai_wrap: got %h want 0000", dat_out); end
    b_read(8'hFF);
    n_cmp++; if (b_dout !== 16'h0001) begin n_mis++; $display("FAIL ai_wrap_mem: got %h want 0001", b_dout); end
    cpu_write(A_CTRL, 16'h0000);
    cpu_write(A_DWR, 16'h0042);
    cpu_read(A_ADDR);
    n_cmp++; if (dat_out !== 16'h0000) begin n_mis++; $display("FAIL ai_off: got %h want 0000", dat_out); end
  endtask
`else
  task automatic test_no_autoinc();
    cpu_write(A_ADDR, 16'h0005);
    cpu_write(A_CTRL, 16'h0001);   // ignored in this build
    cpu_write(A_DWR, 16'h0011);
    cpu_write(A_DWR, 16'h0022);
    cpu_write(A_DWR, 16'h0033);
    cpu_read(A_ADDR);
    n_cmp++; if (dat_out !== 16'h0005) begin n_mis++; $display("FAIL noai_ptr: got %h want 0005", dat_out); end
    b_read(8'h05);
    n_cmp++; if (b_dout !== 16'h0033) begin n_mis++; $display("FAIL noai_mem: got %h want 0033", b_dout); end
    b_read(8'h06);
    n_cmp++; if (b_dout === 16'h0022) begin n_mis++; $display("FAIL noai_next: got %h want not 0022", b_dout); end
  endtask
`endif

  initial begin
    rst_n = 1'b0; cs = 1'b0; wr = 1'b0; rd = 1'b0; addr = 4'h0; dat_in = 16'h0000;
    b_addr = 8'h00; b_din = 16'h0000; b_we = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    idle_cycle();
    test_reset();
    test_addr_data();
    test_wr_rd_both();
    test_collision();
    test_clear();
    test_reset_mid_sweep();
`ifdef DPRAM_AUTOINC_EN
    test_autoinc();
`else
    test_no_autoinc();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/dpram_io_bridge.md
# dpram_io_bridge

Parametrised successor to the J1 I/O-mapped dual-port RAM interface. It exposes port A of a true dual-port RAM to the J1 CPU through a small register window. The window supports an address pointer with optional auto-increment, registered reads, a hardware clear sweep and sticky error reporting. Port B is brought out unchanged for a hardware peer such as a display or DMA engine.

## Interface
- DW, 16: RAM word width, 1..16; narrower words are zero-extended onto `dat_out`.
- AW, 8: RAM address width; DEPTH = 2**AW.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cs`  in  1  chip select from the J1 I/O decoder.
- `addr`  in  4  register offset (low bits of the J1 I/O address).
- `wr`  in  1  write strobe; a write is `cs && wr`.
- `rd`  in  1  read strobe; a read is `cs && rd`.
- `dat_in`  in  16  CPU write data.
- `dat_out`  out  16  CPU read data, registered.
- `b_addr`  in  AW  port B address.
- `b_din`  in  DW  port B write data.
- `b_we`  in  1  port B write enable.
- `b_dout`  out  DW  port B read data, 1-cycle latency.
- `busy`  out  1  clear sweep in progress.

## Operation
- Register map, by `addr`:
  - 0x0 DATA_WR (write): mem[ptr] <= `dat_in[DW-1:0]`; ptr advances.
  - 0x2 DATA_RD (read): start a read of mem[ptr]; ptr advances.
  - 0x4 ADDR (write): ptr <= `dat_in[AW-1:0]`. ADDR (read): `dat_out` <= ptr.
  - 0x6 STATUS (read): `dat_out` <= {13'b0, rd_pend, err, busy}. STATUS (write): `dat_in[1]`=1 clears err.
  - 0x8 INIT (write): start the clear sweep.
  - 0xA CTRL (write): bit0 = autoinc.
  - Any other offset: no effect; `dat_out` holds.
- Pointer advance: ptr <= ptr+1 when autoinc=1. DEPTH-1 wraps to 0.
- FSM, IDLE -> CLEAR on an INIT write:
  - CLEAR writes 0 to port A addresses 0..DEPTH-1, one per cycle, then returns to IDLE.
  - ptr is set to 0 on exit.
- While in CLEAR:
  - DATA_WR, DATA_RD, ADDR-write and CTRL accesses are ignored and set err.
  - STATUS accesses work normally.
  - A second INIT write is ignored, with no err.
- Port B is independent of the FSM and of port A.
- Same-address collision on the same cycle:
  - Both ports writing: the port A value is stored.
  - A read collides with a write: the read returns the old data.
- Reset values: `dat_out`=0, `b_dout`=0, ptr=0, state=IDLE, `busy`=0, err=0, rd_pend=0, autoinc=1. RAM contents are not reset.
- Reset asserted mid-sweep aborts the sweep. Memory words not yet cleared keep their old values.

## Timing
- DATA_WR strobe in cycle N: RAM written at the edge ending N; ptr updates at the same edge.
- DATA_RD strobe in cycle N:
  - Port A address latched at the end of N.
  - `dat_out` loaded at the end of N+1.
  - rd_pend=1 during N+1.
- Back-to-back DATA_RD strobes are legal and pipeline at one word per cycle.
- ADDR and STATUS reads: `dat_out` is loaded at the end of the strobe cycle.
- CLEAR lasts exactly DEPTH cycles. `busy` rises the edge after the INIT write and falls the edge after the last write.
- `wr` and `rd` both high with `cs`: the write takes effect; the read is ignored.

## Configuration
- `DPRAM_AUTOINC_EN` defined: the autoinc bit and the CTRL register exist as described above.
- `DPRAM_AUTOINC_EN` undefined:
  - ptr never advances after data accesses.
  - CTRL writes are ignored.
  - The STATUS read contains no autoinc state.
  - autoinc is constant 0.

## Structure
- Package `dpram_pkg`: register offsets (REG_DATA_WR, REG_DATA_RD, REG_ADDR, REG_STATUS, REG_INIT, REG_CTRL), FSM state typedef (ST_IDLE, ST_CLEAR), STATUS bit positions.
- Sub-module `dpram_core`: parametrised true dual-port synchronous RAM (DW, AW), with a registered output per port and port A write priority.

## Test plan
- Write 0x1234 to ADDR, write DATA_WR 0xBEEF, 0xCAFE, then ADDR=0x1234[7:0]=0x34 and two DATA_RD strobes -> `dat_out` = 0xBEEF, then 0xCAFE, 2 edges after each strobe; final ptr = 0x36.
- ptr=0xFF with autoinc, DATA_WR 0x0001 -> mem[0xFF]=1, ptr=0x00.
- INIT write -> `busy` high for 256 cycles; a DATA_WR during the sweep sets err=1 and mem is unchanged; afterwards every port B read returns 0; a STATUS write of 0x0002 clears err.
- Port A and port B both write addr 0x10 in the same cycle (0xAAAA / 0x5555) -> port B read of 0x10 returns 0xAAAA.
- `rst_n` low at cycle 100 of a sweep -> `busy`=0, ptr=0, `dat_out`=0 immediately; words 100..255 keep their pre-sweep contents.
- Without `DPRAM_AUTOINC_EN`: three DATA_WR strobes at ptr=5 -> ptr stays 5, mem[5] = last value written.
